// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined) with valid/ready byte output, frame/parity error pulses and sticky overrun
module uart_rx_deframer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       busy_o,
  output logic       frame_err_o,
  output logic       parity_err_o,
  output logic       overrun_o
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic rx_m_q, rx_m_d, rx_s_q, rx_s_d, rx_d_q, rx_d_d;
  logic valid_q, valid_d, ferr_q, ferr_d, ovr_q, ovr_d, par_ok;
`ifdef UART_RX_PARITY_EN
  logic bad_q, bad_d, perr_q, perr_d;
  assign par_ok = ~bad_q;
  assign parity_err_o = perr_q;
`else
  assign par_ok = 1'b1;
  assign parity_err_o = 1'b0;
`endif
  always_comb begin
    rx_m_d = rx_i;
    rx_s_d = rx_m_q;
    rx_d_d = rx_s_q;
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    bit_d = bit_q;
    shift_d = shift_q;
    data_d = data_q;
    valid_d = valid_q & ~ready_i;
    ferr_d = 1'b0;
    ovr_d = ovr_q;
`ifdef UART_RX_PARITY_EN
    bad_d = bad_q;
    perr_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        state_d = (rx_d_q & ~rx_s_q) ? START : IDLE;
      end
      START: if (cnt_q == HALF) begin
        cnt_d = '0;
        bit_d = '0;
        state_d = rx_s_q ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
        bad_d = 1'b0;
`endif
      end
      DATA: if (cnt_q == FULL) begin
        cnt_d = '0;
        shift_d = {rx_s_q, shift_q[7:1]};
        bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
        state_d = (bit_q == 3'd7) ? PARITY : DATA;
`else
        state_d = (bit_q == 3'd7) ? STOP : DATA;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt_q == FULL) begin
        cnt_d = '0;
        perr_d = rx_s_q ^ (^shift_q);
        bad_d = perr_d;
        state_d = STOP;
      end
`endif
      STOP: if (cnt_q == FULL) begin
        state_d = IDLE;
        ferr_d = ~rx_s_q;
        // a transfer in this same cycle frees the holding register for the new byte
        if (rx_s_q & par_ok) begin
          if (!valid_q || ready_i) begin
            data_d = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m_q <= 1'b1;
      rx_s_q <= 1'b1;
      rx_d_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      bad_q <= 1'b0;
      perr_q <= 1'b0;
`endif
    end else begin
      rx_m_q <= rx_m_d;
      rx_s_q <= rx_s_d;
      rx_d_q <= rx_d_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
`ifdef UART_RX_PARITY_EN
      bad_q <= bad_d;
      perr_q <= perr_d;
`endif
    end
  end
  assign data_o = data_q;
  assign valid_o = valid_q;
  assign busy_o = state_q != IDLE;
  assign frame_err_o = ferr_q;
  assign overrun_o = ovr_q;
endmodule
